// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package loader_pkg;

  // Loader sequencing: two length bytes, payload, checksum, then a terminal state.
  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into 32-bit little-endian words; first byte lands in bits 7:0.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [IDX_W-1:0] idx;
  logic [23:0]      sr;

  // Incoming byte becomes the top byte; earlier bytes have already slid down.
  assign word       = {data, sr};
  assign word_valid = shift && (idx == IDX_W'(BYTES_PER_WORD - 1));

  // Byte index and partial-word shift register; clear drops any partial word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
      sr  <= '0;
    end else if (clear) begin
      idx <= '0;
      sr  <= '0;
    end else if (shift) begin
      idx <= idx + 1'b1;
      sr  <= word[31:8];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream, writes
// the packed words into imem and releases the core from reset on a clean load.
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  // Largest legal word count: the whole memory, no wrap.
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t      state, state_nxt;
  logic [15:0] len;
  logic [7:0]  acc;
  logic        xfer;
  logic        pk_shift, pk_clear;
  logic [31:0] pk_word;
  logic        pk_word_valid;
  logic [16:0] hdr_len;
  logic        last_word;

  assign xfer      = in_valid && in_ready;
  assign hdr_len   = {1'b0, in_data, len[7:0]};
  assign last_word = (17'(words_loaded) + 17'd1) == {1'b0, len};

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pk_clear),
    .shift      (pk_shift),
    .data       (in_data),
    .word       (pk_word),
    .word_valid (pk_word_valid)
  );

  // Next-state, handshake and packer control.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    pk_shift  = 1'b0;
    pk_clear  = 1'b0;
    case (state)
      LEN0: begin
        in_ready = 1'b1;
        if (xfer) state_nxt = LEN1;
      end
      LEN1: begin
        in_ready = 1'b1;
        if (xfer) begin
          if (hdr_len > CAP)       state_nxt = ERR;
          else if (hdr_len == '0)  state_nxt = CHK;
          else                     state_nxt = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        pk_shift = xfer;
        if (pk_word_valid && last_word) state_nxt = CHK;
      end
      CHK: begin
        in_ready = 1'b1;
        if (xfer) state_nxt = (in_data == acc) ? DONE : ERR;
      end
      DONE, ERR: begin
        if (start) begin
          state_nxt = LEN0;
          pk_clear  = 1'b1;
        end
      end
      default: state_nxt = LEN0;
    endcase
  end

  // State register plus status outputs, registered off the next state so
  // core_reset never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LEN0;
      done       <= 1'b0;
      error      <= 1'b0;
      core_reset <= 1'b1;
    end else begin
      state      <= state_nxt;
      done       <= (state_nxt == DONE);
      error      <= (state_nxt == ERR);
      core_reset <= (state_nxt != DONE);
    end
  end

  // Length capture and running checksum over payload bytes only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len <= '0;
      acc <= '0;
    end else begin
      if (state == LEN0 && xfer) len[7:0]  <= in_data;
      if (state == LEN1 && xfer) len[15:8] <= in_data;
      if (pk_clear)      acc <= '0;
      else if (pk_shift) acc <= acc ^ in_data;
    end
  end

  // imem write port: one strobe cycle per completed word, address follows count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we       <= 1'b0;
      mem_addr     <= ADDR_W'(BASE_ADDR);
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      mem_we <= pk_word_valid;
      if (pk_word_valid) begin
        mem_wdata    <= pk_word;
        mem_addr     <= ADDR_W'(BASE_ADDR) + words_loaded[ADDR_W-1:0];
        words_loaded <= words_loaded + 1'b1;
      end else if (pk_clear) begin
        words_loaded <= '0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load scenarios, reset corner case and random
// loads, all checked against a stream-level reference model.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              start = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_reset;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .start        (start),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_reset   (core_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  logic [7:0]        strm[$];

  logic [31:0] m_w[$];
  bit          m_done, m_err;
  int          m_wl;

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Stream = len lo, len hi, 4*N payload bytes (LE words), XOR checksum.
  task automatic build(input int n, input logic [2:0][31:0] w, input bit corrupt, input bit rnd);
    logic [7:0]  x;
    logic [31:0] wd;
    strm.delete();
    strm.push_back(n[7:0]);
    strm.push_back(n[15:8]);
    if (n > (1 << ADDR_W)) return;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (rnd)        wd = $urandom;
      else if (i < 3) wd = w[i];
      else            wd = 32'h9E3779B9 * 32'(i + 1);
      for (int b = 0; b < 4; b++) begin
        strm.push_back(wd[8*b +: 8]);
        x = x ^ wd[8*b +: 8];
      end
    end
    strm.push_back(x ^ {7'd0, corrupt});
  endtask

  // Reference: interpret the byte stream directly.
  task automatic run_model();
    int         n;
    logic [7:0] x;
    logic [31:0] wd;
    m_w.delete();
    n = int'(strm[0]) + 256 * int'(strm[1]);
    if (n > (1 << ADDR_W)) begin
      m_err = 1; m_done = 0; m_wl = 0;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      wd = 32'h0;
      for (int b = 0; b < 4; b++) begin
        wd = wd | (32'(strm[2 + 4*i + b]) << (8*b));
        x  = x ^ strm[2 + 4*i + b];
      end
      m_w.push_back(wd);
    end
    m_done = (strm[2 + 4*n] == x);
    m_err  = !m_done;
    m_wl   = n;
  endtask

  // Present one byte from a negedge; returns at the negedge after the transfer.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: in_ready stayed 0, required 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input int gap_max);
    for (int i = first; i <= last; i++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_byte(strm[i]);
    end
  endtask

  task automatic check_result(input string tag);
    check({tag, "_done"}, done, m_done);
    check({tag, "_error"}, error, m_err);
    check({tag, "_core_reset"}, core_reset, !m_done);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_words_loaded"}, words_loaded, m_wl);
    check({tag, "_wr_cnt"}, wr_data_q.size(), m_w.size());
    for (int i = 0; i < m_w.size() && i < wr_data_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], i);
      check($sformatf("%s_data%0d", tag, i), wr_data_q[i], m_w[i]);
    end
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_rs_in_ready"}, in_ready, 1'b1);
    check({tag, "_rs_done"}, done, 1'b0);
    check({tag, "_rs_error"}, error, 1'b0);
    check({tag, "_rs_core_reset"}, core_reset, 1'b1);
    check({tag, "_rs_words"}, words_loaded, 0);
  endtask

  typedef struct {
    int               n;
    logic [2:0][31:0] w;
    bit               corrupt;
    int               gap;
    bit               e_done;
    bit               e_err;
    int               e_wl;
  } vec_t;

  vec_t tab[8];

  initial begin
    tab[0] = '{1,   {32'h0, 32'h0, 32'h12345678},               1'b0, 0, 1'b1, 1'b0, 1};
    tab[1] = '{1,   {32'h0, 32'h0, 32'h12345678},               1'b1, 0, 1'b0, 1'b1, 1};
    tab[2] = '{0,   {32'h0, 32'h0, 32'h0},                      1'b0, 0, 1'b1, 1'b0, 0};
    tab[3] = '{257, {32'h0, 32'h0, 32'h0},                      1'b0, 0, 1'b0, 1'b1, 0};
    tab[4] = '{256, {32'h0, 32'h0, 32'h0},                      1'b0, 0, 1'b1, 1'b0, 256};
    tab[5] = '{3,   {32'hFFFFFFFF, 32'h00000000, 32'h2008000A}, 1'b0, 0, 1'b1, 1'b0, 3};
    tab[6] = '{3,   {32'hFFFFFFFF, 32'h00000000, 32'h2008000A}, 1'b0, 5, 1'b1, 1'b0, 3};
    tab[7] = '{2,   {32'h0, 32'hA5A5A5A5, 32'h01020304},        1'b1, 3, 1'b0, 1'b1, 2};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_core_reset", core_reset, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_words", words_loaded, 0);
    check("rst_in_ready", in_ready, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_core_reset", core_reset, 1'b1);

    // Scenario table.
    for (int k = 0; k < 8; k++) begin
      string tag;
      tag = $sformatf("v%0d", k);
      wr_addr_q.delete();
      wr_data_q.delete();
      build(tab[k].n, tab[k].w, tab[k].corrupt, 1'b0);
      send_range(0, strm.size() - 1, tab[k].gap);
      repeat (3) @(negedge clk);
      run_model();
      check_result(tag);
      check({tag, "_tab_done"}, done, tab[k].e_done);
      check({tag, "_tab_error"}, error, tab[k].e_err);
      check({tag, "_tab_words"}, words_loaded, tab[k].e_wl);
      pulse_start(tag);
    end

    // Start is ignored mid-load; a stray pulse must not disturb the stream.
    wr_addr_q.delete();
    wr_data_q.delete();
    build(2, {32'h0, 32'h55667788, 32'h11223344}, 1'b0, 1'b0);
    send_range(0, 4, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_range(5, strm.size() - 1, 0);
    repeat (3) @(negedge clk);
    run_model();
    check_result("ign_start");
    pulse_start("ign_start");

    // Reset after 3 bytes of word 1: no partial write, core stays held.
    wr_addr_q.delete();
    wr_data_q.delete();
    build(1, {32'h0, 32'h0, 32'hCAFEF00D}, 1'b0, 1'b0);
    send_range(0, 4, 0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_mem_we", mem_we, 1'b0);
    check("mid_rst_core_reset", core_reset, 1'b1);
    check("mid_rst_words", words_loaded, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_wr_cnt", wr_data_q.size(), 0);
    check("mid_rst_done", done, 1'b0);
    send_range(0, strm.size() - 1, 0);
    repeat (3) @(negedge clk);
    run_model();
    check_result("after_rst");
    pulse_start("after_rst");

    // Random loads with random gaps and occasional bad checksums.
    for (int r = 0; r < 8; r++) begin
      string tag;
      tag = $sformatf("rnd%0d", r);
      wr_addr_q.delete();
      wr_data_q.delete();
      build($urandom_range(0, 8), '0, bit'($urandom_range(0, 1)), 1'b1);
      send_range(0, strm.size() - 1, 4);
      repeat (3) @(negedge clk);
      run_model();
      check_result(tag);
      pulse_start(tag);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
